id_stage: RTL

Registered instruction-decode stage for the pipelined RV32I core, sitting between fetch (IF) and execute (EX). It accepts one instruction per cycle over a valid/ready handshake and decodes it into immediate, register addresses and control fields. It holds the result in an ID/EX pipeline register, inserts one bubble on a load-use hazard and drops in-flight work on a branch/jump flush. It generalises the combinational decoder with a data-width parameter, backpressure, hazard detection and an optional illegal-instruction flag.

---
 rtl/id_stage.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
//------------------------------------------------------------------------------
// Module      : id_stage
// Description : RV32I decode stage with an ID/EX register, a valid/ready
//               handshake, load-use bubble insertion and flush. Defining
//               ID_ILLEGAL_TRAP_EN adds the registered out_illegal flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [RA_W-1:0] out_rs1_addr,
    output logic [RA_W-1:0] out_rs2_addr,
    output logic [RA_W-1:0] out_rd_addr,
    output logic [4:0]      out_exe_fun,
    output logic [1:0]      out_op1_sel,
    output logic [1:0]      out_op2_sel,
    output logic            out_mem_wen,
    output logic            out_rf_wen,
`ifdef ID_ILLEGAL_TRAP_EN
    output logic            out_illegal,
`endif
    output logic [1:0]      out_wb_sel
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [4:0] c_FUN_ADD  = 5'd1,  c_FUN_SUB  = 5'd2,  c_FUN_AND  = 5'd3;
    localparam logic [4:0] c_FUN_OR   = 5'd4,  c_FUN_XOR  = 5'd5,  c_FUN_SLL  = 5'd6;
    localparam logic [4:0] c_FUN_SRL  = 5'd7,  c_FUN_SRA  = 5'd8,  c_FUN_SLT  = 5'd9;
    localparam logic [4:0] c_FUN_SLTU = 5'd10, c_FUN_BEQ  = 5'd11, c_FUN_JALR = 5'd17;

    localparam logic [1:0] c_OP1_RS1 = 2'd1, c_OP1_PC  = 2'd2;
    localparam logic [1:0] c_OP2_RS2 = 2'd1, c_OP2_IMM = 2'd2;
    localparam logic [1:0] c_WB_ALU  = 2'd1, c_WB_MEM  = 2'd2, c_WB_PC = 2'd3;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [RA_W-1:0]       w_rs1, w_rs2, w_rd;
    logic signed [31:0]    w_imm32;
    logic [4:0]            w_fun;
    logic [1:0]            w_op1, w_op2, w_wb;
    logic                  w_mem_wen, w_rf_we, w_legal;
    logic                  w_uses_rs1, w_uses_rs2, w_hazard, w_accept;

    logic                  r_valid;
    logic [XLEN-1:0]       r_pc, r_imm;
    logic [RA_W-1:0]       r_rs1, r_rs2, r_rd;
    logic [4:0]            r_fun;
    logic [1:0]            r_op1, r_op2, r_wb;
    logic                  r_mem_wen, r_rf_wen, r_illegal;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];
    assign w_rs1    = RA_W'(in_inst[19:15]);
    assign w_rs2    = RA_W'(in_inst[24:20]);
    assign w_rd     = RA_W'(in_inst[11:7]);

    always_comb begin
        w_fun     = 5'd0;
        w_op1     = 2'd0;
        w_op2     = 2'd0;
        w_wb      = 2'd0;
        w_mem_wen = 1'b0;
        w_rf_we   = 1'b0;
        w_imm32   = 32'sd0;
        w_legal   = 1'b0;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC: begin
                w_legal = 1'b1;
                w_imm32 = {in_inst[31:12], 12'b0};
                w_fun   = c_FUN_ADD;
                w_op1   = (w_opcode == c_OP_AUIPC) ? c_OP1_PC : 2'd0;
                w_op2   = c_OP2_IMM;
                w_wb    = c_WB_ALU;
                w_rf_we = 1'b1;
            end
            c_OP_JAL: begin
                w_legal = 1'b1;
                w_imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                w_fun   = c_FUN_ADD;
                w_op1   = c_OP1_PC;
                w_op2   = c_OP2_IMM;
                w_wb    = c_WB_PC;
                w_rf_we = 1'b1;
            end
            c_OP_JALR, c_OP_LOAD: begin
                if ((w_opcode == c_OP_JALR && w_funct3 == 3'b000) ||
                    (w_opcode == c_OP_LOAD && w_funct3 == 3'b010)) begin
                    w_legal = 1'b1;
                    w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    w_fun   = (w_opcode == c_OP_JALR) ? c_FUN_JALR : c_FUN_ADD;
                    w_op1   = c_OP1_RS1;
                    w_op2   = c_OP2_IMM;
                    w_wb    = (w_opcode == c_OP_JALR) ? c_WB_PC : c_WB_MEM;
                    w_rf_we = 1'b1;
                end
            end
            c_OP_STORE: begin
                if (w_funct3 == 3'b010) begin
                    w_legal   = 1'b1;
                    w_imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                    w_fun     = c_FUN_ADD;
                    w_op1     = c_OP1_RS1;
                    w_op2     = c_OP2_IMM;
                    w_mem_wen = 1'b1;
                end
            end
            c_OP_BRANCH: begin
                if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
                    w_legal = 1'b1;
                    w_imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                    // funct3 000,001,100..111 map onto BEQ,BNE,BLT..BGEU
                    w_fun   = c_FUN_BEQ + ((w_funct3[2]) ? {3'b0, w_funct3[1:0]} + 5'd2
                                                         : {4'b0, w_funct3[0]});
                    w_op1   = c_OP1_RS1;
                    w_op2   = c_OP2_RS2;
                end
            end
            c_OP_IMM, c_OP_REG: begin
                w_legal = 1'b1;
                case (w_funct3)
                    3'b000: w_fun = (w_opcode == c_OP_REG && w_funct7 == c_F7_ALT) ? c_FUN_SUB : c_FUN_ADD;
                    3'b001: w_fun = c_FUN_SLL;
                    3'b010: w_fun = c_FUN_SLT;
                    3'b011: w_fun = c_FUN_SLTU;
                    3'b100: w_fun = c_FUN_XOR;
                    3'b101: w_fun = (w_funct7 == c_F7_ALT) ? c_FUN_SRA : c_FUN_SRL;
                    3'b110: w_fun = c_FUN_OR;
                    default: w_fun = c_FUN_AND;
                endcase
                // Shifts always constrain funct7; OP constrains it for every funct3.
                if ((w_opcode == c_OP_REG || w_funct3 == 3'b001 || w_funct3 == 3'b101) &&
                    !(w_funct7 == c_F7_ZERO ||
                      (w_funct7 == c_F7_ALT && (w_funct3 == 3'b101 ||
                                                (w_funct3 == 3'b000 && w_opcode == c_OP_REG))))) begin
                    w_legal = 1'b0;
                    w_fun   = 5'd0;
                end else begin
                    w_imm32 = (w_opcode == c_OP_IMM) ? {{20{in_inst[31]}}, in_inst[31:20]} : 32'sd0;
                    w_op1   = c_OP1_RS1;
                    w_op2   = (w_opcode == c_OP_IMM) ? c_OP2_IMM : c_OP2_RS2;
                    w_wb    = c_WB_ALU;
                    w_rf_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_uses_rs1 = !(w_opcode == c_OP_LUI || w_opcode == c_OP_AUIPC || w_opcode == c_OP_JAL);
    assign w_uses_rs2 = (w_opcode == c_OP_REG || w_opcode == c_OP_STORE || w_opcode == c_OP_BRANCH);
    assign w_hazard   = in_valid && r_valid && r_wb == c_WB_MEM && r_rd != '0 &&
                        ((w_uses_rs1 && w_rs1 == r_rd) || (w_uses_rs2 && w_rs2 == r_rd));
    assign in_ready   = flush || ((!r_valid || out_ready) && !w_hazard);
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_fun     <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_wb      <= '0;
            r_mem_wen <= 1'b0;
            r_rf_wen  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush || (w_hazard && out_ready)) begin
            r_valid   <= 1'b0;
            r_mem_wen <= 1'b0;
            r_rf_wen  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= in_pc;
            r_imm     <= XLEN'(w_imm32);
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_fun     <= w_fun;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_wb      <= w_wb;
            r_mem_wen <= w_mem_wen;
            r_rf_wen  <= w_rf_we && (w_rd != '0);
            r_illegal <= !w_legal;
        end else if (r_valid && out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_imm      = r_imm;
    assign out_rs1_addr = r_rs1;
    assign out_rs2_addr = r_rs2;
    assign out_rd_addr  = r_rd;
    assign out_exe_fun  = r_fun;
    assign out_op1_sel  = r_op1;
    assign out_op2_sel  = r_op2;
    assign out_wb_sel   = r_wb;
    assign out_mem_wen  = r_mem_wen;
    assign out_rf_wen   = r_rf_wen;
`ifdef ID_ILLEGAL_TRAP_EN
    assign out_illegal  = r_illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = r_illegal;
`endif

endmodule

`default_nettype wire
